split_arbiter: RTL and testbench
================================

// Module: split_arbiter
// PURPOSE
//  Split-aware two-master bus arbiter for the serial system bus. It sits beside the bus interconnect.
//  Grants the bus to one master per transaction, using round-robin on ties.
//  Drives the slave and master mux selects.
//  When the addressed slave asserts split, it parks the owner and lends the bus to the other master.
//  When split clears, it resumes the parked master.
// PARAMETERS
//  SLAVE_LEN     2    slave-id width; id 0 is illegal, ids 1..NUM_SLAVES are valid
//  NUM_SLAVES    3    number of slaves, and the width of s_split_en
//  TIMEOUT_MAX   100  cycles a granted master may hold the bus without trans_done
// PORTS
//  clk            in   1           bus clock
//  rst            in   1           synchronous reset, active-low
//  m1_request     in   1           master 1 bus request, level, held until done
//  m2_request     in   1           master 2 bus request
//  m1_slave_id    in   SLAVE_LEN   master 1 target slave, valid while m1_request=1
//  m2_slave_id    in   SLAVE_LEN   master 2 target slave
//  trans_done     in   1           one-cycle pulse from the owning master at end of transfer
//  s_split_en     in   NUM_SLAVES  bit i=1: slave i+1 requests split
//  m1_grant       out  1           bus granted to master 1
//  m2_grant       out  1           bus granted to master 2
//  arbiter_busy   out  1           FSM not in IDLE
//  bus_busy       out  1           m1_grant | m2_grant
//  slave_sel      out  SLAVE_LEN   slave routed by interconnect; 0 when no grant
//  master_sel     out  1           0=m1, 1=m2 drives the bus mux
//  split_parked   out  2           bit0/bit1: m1/m2 parked on a split slave
//  timeout        out  1           one-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  Reset (rst=0 at posedge), including mid-transfer:
//   - all outputs 0 and state=IDLE at the next edge
//   - parked info cleared; rr pointer = m2, so m1 wins the first tie
//  All outputs are registered.
//  A request with a valid id sampled at edge N gives a grant visible after edge N+1 (1-cycle latency).
//  States: IDLE, GRANT, SPLIT_WAIT, SPLIT_GRANT.
//  IDLE:
//   - one valid requester -> it wins
//   - both -> winner is the master not equal to the rr pointer
//   - load owner and slave_sel=id -> GRANT
//   - id 0 requests are ignored (no grant, no error)
//  GRANT (owner keeps grant):
//   - trans_done -> drop grant, rr pointer=owner, IDLE
//   - owner drops request w/o done -> abort, IDLE
//   - s_split_en[slave_sel-1]=1 -> park owner (split_parked bit, saved id), drop grant;
//     other master has a valid request to a different slave -> grant it, SPLIT_GRANT
//     otherwise -> SPLIT_WAIT
//  SPLIT_WAIT (no grant, slave_sel=0, arbiter_busy=1):
//   - split bit clears -> re-grant parked master with saved id, clear parked, GRANT
//   - else other master requests a non-split slave -> SPLIT_GRANT
//   - split release has priority over a new request in the same cycle
//  SPLIT_GRANT:
//   - split release is latched (resume_pend) and never preempts the borrowing master
//   - on trans_done / abort / timeout: resume_pend or split already clear -> resume parked master, GRANT;
//     otherwise -> SPLIT_WAIT
//   - a borrower cannot split; its slave's split bit is ignored
//  Requests for a slave that is currently split are blocked until the parked master resumes.
//  Same-cycle conflicts: trans_done beats split_en and timeout.
//  Timeout:
//   - counter cleared on every grant change; increments each cycle a grant is held
//   - at TIMEOUT_MAX-1 without done: pulse timeout, revoke grant, continue as for trans_done
//     (rr pointer updated)
//   - no timeout in SPLIT_WAIT
//  m1_grant and m2_grant are never both 1. slave_sel is nonzero iff bus_busy=1.
// STRUCTURE
//  Shared bus_defs.vh holds:
//   - state encodings
//   - master ids M1=0 and M2=1
//   - slave id constants and SLAVE_LEN
//  Sub-module arb_timeout_counter(clk, rst, clear, enable, expired) is parameterised by TIMEOUT_MAX.
//  Everything else is a single FSM with registered outputs.
// TESTING
//  1. Reset mid-grant: m1 granted, rst=0 one cycle -> all outputs 0 next edge, state IDLE.
//  2. Tie and round-robin:
//     - m1 and m2 both request slave 1 from reset -> m1_grant after 1 cycle, slave_sel=1
//     - m1 done, both still requesting -> m2_grant, master_sel=1
//  3. Split lend:
//     - m1 granted to slave 2; s_split_en=3'b010 -> m1_grant drops, split_parked=01
//     - m2 requesting slave 3 -> m2_grant, slave_sel=3
//     - split clears mid-m2 -> m2 keeps bus; after m2 done -> m1_grant, slave_sel=2
//  4. Split blocking: m1 parked on slave 2, m2 requests slave 2 -> no grant until split clears and m1 completes.
//  5. Timeout: TIMEOUT_MAX=8, m2 granted, no done -> grant held 8 cycles, timeout pulse, m2_grant=0, IDLE.
//  6. Illegal and conflicting inputs:
//     - request with id 0 -> no grant
//     - trans_done and split_en in the same cycle -> transfer completes, no park

Source files
------------

// File: rtl/split_arbiter_pkg.sv
// Shared definitions for the split-aware two-master arbiter: FSM states,
// master ids, slave id constants and default sizing.
package split_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SPLIT_WAIT,
        ST_SPLIT_GRANT
    } arb_state_e;

    localparam logic M1 = 1'b0;
    localparam logic M2 = 1'b1;

    localparam int SLAVE_LEN_DEF   = 2;
    localparam int NUM_SLAVES_DEF  = 3;
    localparam int TIMEOUT_MAX_DEF = 100;

    localparam logic [SLAVE_LEN_DEF-1:0] S_NONE = 2'd0;
    localparam logic [SLAVE_LEN_DEF-1:0] S1     = 2'd1;
    localparam logic [SLAVE_LEN_DEF-1:0] S2     = 2'd2;
    localparam logic [SLAVE_LEN_DEF-1:0] S3     = 2'd3;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts cycles a grant has been held; expired flags the last permitted cycle.
module arb_timeout_counter #(
    parameter int TIMEOUT_MAX = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_MAX > 2) ? $clog2(TIMEOUT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_MAX - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Must not depend on clear: clear is derived from the FSM's next grant.
    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/split_arbiter.sv
// Split-aware two-master bus arbiter: round-robin grant, park-and-lend on
// slave split, resume of the parked master, and grant timeout.
module split_arbiter
    import split_arbiter_pkg::*;
#(
    parameter int SLAVE_LEN   = SLAVE_LEN_DEF,
    parameter int NUM_SLAVES  = NUM_SLAVES_DEF,
    parameter int TIMEOUT_MAX = TIMEOUT_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m1_request,
    input  logic                  m2_request,
    input  logic [SLAVE_LEN-1:0]  m1_slave_id,
    input  logic [SLAVE_LEN-1:0]  m2_slave_id,
    input  logic                  trans_done,
    input  logic [NUM_SLAVES-1:0] s_split_en,
    output logic                  m1_grant,
    output logic                  m2_grant,
    output logic                  arbiter_busy,
    output logic                  bus_busy,
    output logic [SLAVE_LEN-1:0]  slave_sel,
    output logic                  master_sel,
    output logic [1:0]            split_parked,
    output logic                  timeout
);

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 rr_q, rr_d;
    logic [1:0]           parked_q, parked_d;
    logic [SLAVE_LEN-1:0] saved_id_q, saved_id_d;
    logic                 resume_pend_q, resume_pend_d;
    logic [1:0]           grant_q, grant_d;
    logic [SLAVE_LEN-1:0] slave_sel_q, slave_sel_d;
    logic                 master_sel_q;
    logic                 busy_q;
    logic                 bus_busy_q;
    logic                 timeout_q, timeout_d;

    logic [1:0]           req;
    logic [SLAVE_LEN-1:0] ids [2];
    logic [1:0]           valid;
    logic                 win, other, park_m, pend_now;
    logic                 tmo_clear, tmo_enable, tmo_expired;

    function automatic logic id_ok(input logic [SLAVE_LEN-1:0] id);
        return (id != '0) && (int'(id) <= NUM_SLAVES);
    endfunction

    function automatic logic split_of(input logic [SLAVE_LEN-1:0] id,
                                      input logic [NUM_SLAVES-1:0] en);
        logic s;
        s = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(id) == i + 1) s = en[i];
        end
        return s;
    endfunction

    function automatic logic [1:0] onehot(input logic m);
        return m ? 2'b10 : 2'b01;
    endfunction

    assign req    = {m2_request, m1_request};
    assign ids[0] = m1_slave_id;
    assign ids[1] = m2_slave_id;

    // A slave held by a parked master cannot be claimed by anyone else.
    always_comb begin
        valid = 2'b00;
        for (int m = 0; m < 2; m++) begin
            valid[m] = req[m] && id_ok(ids[m]) &&
                       !((parked_q != 2'b00) && (ids[m] == saved_id_q));
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        parked_d      = parked_q;
        saved_id_d    = saved_id_q;
        resume_pend_d = resume_pend_q;
        grant_d       = grant_q;
        slave_sel_d   = slave_sel_q;
        timeout_d     = 1'b0;
        win           = 1'b0;
        other         = ~owner_q;
        park_m        = parked_q[1];
        pend_now      = resume_pend_q || !split_of(saved_id_q, s_split_en);

        case (state_q)
            ST_IDLE: begin
                if (valid != 2'b00) begin
                    win         = (valid == 2'b11) ? ~rr_q : valid[1];
                    owner_d     = win;
                    grant_d     = onehot(win);
                    slave_sel_d = ids[win];
                    state_d     = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (trans_done || !req[owner_q]) begin
                    if (trans_done) rr_d = owner_q;
                    grant_d     = 2'b00;
                    slave_sel_d = '0;
                    state_d     = ST_IDLE;
                end else if (split_of(slave_sel_q, s_split_en)) begin
                    parked_d      = onehot(owner_q);
                    saved_id_d    = slave_sel_q;
                    resume_pend_d = 1'b0;
                    if (valid[other] && (ids[other] != slave_sel_q)) begin
                        owner_d     = other;
                        grant_d     = onehot(other);
                        slave_sel_d = ids[other];
                        state_d     = ST_SPLIT_GRANT;
                    end else begin
                        grant_d     = 2'b00;
                        slave_sel_d = '0;
                        state_d     = ST_SPLIT_WAIT;
                    end
                end else if (tmo_expired) begin
                    timeout_d   = 1'b1;
                    rr_d        = owner_q;
                    grant_d     = 2'b00;
                    slave_sel_d = '0;
                    state_d     = ST_IDLE;
                end
            end

            ST_SPLIT_WAIT: begin
                // Release of the split slave outranks a borrower request.
                if (!split_of(saved_id_q, s_split_en)) begin
                    owner_d       = park_m;
                    grant_d       = onehot(park_m);
                    slave_sel_d   = saved_id_q;
                    parked_d      = 2'b00;
                    saved_id_d    = '0;
                    resume_pend_d = 1'b0;
                    state_d       = ST_GRANT;
                end else if (valid[~park_m]) begin
                    owner_d     = ~park_m;
                    grant_d     = onehot(~park_m);
                    slave_sel_d = ids[~park_m];
                    state_d     = ST_SPLIT_GRANT;
                end
            end

            ST_SPLIT_GRANT: begin
                resume_pend_d = pend_now;
                if (trans_done || !req[owner_q] || tmo_expired) begin
                    timeout_d = !trans_done && req[owner_q];
                    if (trans_done || req[owner_q]) rr_d = owner_q;
                    resume_pend_d = 1'b0;
                    if (pend_now) begin
                        owner_d     = park_m;
                        grant_d     = onehot(park_m);
                        slave_sel_d = saved_id_q;
                        parked_d    = 2'b00;
                        saved_id_d  = '0;
                        state_d     = ST_GRANT;
                    end else begin
                        grant_d     = 2'b00;
                        slave_sel_d = '0;
                        state_d     = ST_SPLIT_WAIT;
                    end
                end
            end

            default: begin
                grant_d     = 2'b00;
                slave_sel_d = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign tmo_clear  = (grant_d != grant_q);
    assign tmo_enable = (grant_q != 2'b00);

    arb_timeout_counter #(
        .TIMEOUT_MAX(TIMEOUT_MAX)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= M1;
            rr_q          <= M2;
            parked_q      <= 2'b00;
            saved_id_q    <= '0;
            resume_pend_q <= 1'b0;
            grant_q       <= 2'b00;
            slave_sel_q   <= '0;
            master_sel_q  <= 1'b0;
            busy_q        <= 1'b0;
            bus_busy_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            parked_q      <= parked_d;
            saved_id_q    <= saved_id_d;
            resume_pend_q <= resume_pend_d;
            grant_q       <= grant_d;
            slave_sel_q   <= slave_sel_d;
            master_sel_q  <= grant_d[1];
            busy_q        <= (state_d != ST_IDLE);
            bus_busy_q    <= (grant_d != 2'b00);
            timeout_q     <= timeout_d;
        end
    end

    assign m1_grant     = grant_q[0];
    assign m2_grant     = grant_q[1];
    assign arbiter_busy = busy_q;
    assign bus_busy     = bus_busy_q;
    assign slave_sel    = slave_sel_q;
    assign master_sel   = master_sel_q;
    assign split_parked = parked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_split_arbiter.sv
// Directed, table-driven bench for split_arbiter with hand-computed expectations.
module tb_split_arbiter;
    import split_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       m1_request, m2_request;
    logic [1:0] m1_slave_id, m2_slave_id;
    logic       trans_done;
    logic [2:0] s_split_en;
    logic       m1_grant, m2_grant, arbiter_busy, bus_busy;
    logic [1:0] slave_sel;
    logic       master_sel;
    logic [1:0] split_parked;
    logic       timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    split_arbiter #(
        .SLAVE_LEN  (2),
        .NUM_SLAVES (3),
        .TIMEOUT_MAX(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m1_request  (m1_request),
        .m2_request  (m2_request),
        .m1_slave_id (m1_slave_id),
        .m2_slave_id (m2_slave_id),
        .trans_done  (trans_done),
        .s_split_en  (s_split_en),
        .m1_grant    (m1_grant),
        .m2_grant    (m2_grant),
        .arbiter_busy(arbiter_busy),
        .bus_busy    (bus_busy),
        .slave_sel   (slave_sel),
        .master_sel  (master_sel),
        .split_parked(split_parked),
        .timeout     (timeout)
    );

    // Expected outputs packed as {m1g, m2g, busy, bbusy, sel[1:0], msel, park[1:0], timeout}.
    typedef struct {
        string      name;
        logic       rst;
        logic       m1r;
        logic [1:0] m1id;
        logic       m2r;
        logic [1:0] m2id;
        logic       done;
        logic [2:0] split;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic r,
                                input logic m1r, input logic [1:0] m1id,
                                input logic m2r, input logic [1:0] m2id,
                                input logic done, input logic [2:0] split,
                                input logic g1, input logic g2, input logic busy,
                                input logic bb, input logic [1:0] sel, input logic msel,
                                input logic [1:0] park, input logic to);
        vec_t v;
        v.name = name; v.rst = r; v.m1r = m1r; v.m1id = m1id; v.m2r = m2r;
        v.m2id = m2id; v.done = done; v.split = split;
        v.exp  = {g1, g2, busy, bb, sel, msel, park, to};
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic m1r, input logic [1:0] m1id,
                         input logic m2r, input logic [1:0] m2id,
                         input logic done, input logic [2:0] split);
        @(negedge clk);
        rst = r; m1_request = m1r; m1_slave_id = m1id; m2_request = m2r;
        m2_slave_id = m2id; trans_done = done; s_split_en = split;
    endtask

    task automatic check_out(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {m1_grant, m2_grant, arbiter_busy, bus_busy, slave_sel, master_sel,
               split_parked, timeout};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: outputs %b, required %b (m1g m2g busy bbusy sel msel park to)",
                     name, act, exp);
        end
        tests_run++;
        if ((m1_grant && m2_grant) || ((slave_sel != 2'd0) != bus_busy)) begin
            tests_failed++;
            $display("FAIL %s_invariant: m1g=%b m2g=%b sel=%0d bbusy=%b, required exclusive grants and sel!=0 iff bus_busy",
                     name, m1_grant, m2_grant, slave_sel, bus_busy);
        end
    endtask

    task automatic step(input string name, input logic r, input logic m1r,
                        input logic [1:0] m1id, input logic m2r, input logic [1:0] m2id,
                        input logic done, input logic [2:0] split, input logic [9:0] exp);
        drive(r, m1r, m1id, m2r, m2id, done, split);
        @(posedge clk);
        #1;
        check_out(name, exp);
    endtask

    initial begin
        rst = 1'b0; m1_request = 1'b0; m2_request = 1'b0; m1_slave_id = S_NONE;
        m2_slave_id = S_NONE; trans_done = 1'b0; s_split_en = 3'b000;

        //   name            rst m1r m1id   m2r m2id   dn split    g1 g2 bsy bb sel    ms park   to
        add("reset",          0, 0, S_NONE, 0, S_NONE, 0, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("tie_m1",         1, 1, S1,     1, S1,     0, 3'b000,  1, 0, 1, 1, S1,     0, 2'b00, 0);
        add("done_m1",        1, 1, S1,     1, S1,     1, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("rr_m2",          1, 1, S1,     1, S1,     0, 3'b000,  0, 1, 1, 1, S1,     1, 2'b00, 0);
        add("done_m2",        1, 1, S1,     1, S1,     1, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("id0",            1, 1, S_NONE, 0, S_NONE, 0, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("id0_hold",       1, 1, S_NONE, 0, S_NONE, 0, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("m1_s2",          1, 1, S2,     0, S_NONE, 0, 3'b000,  1, 0, 1, 1, S2,     0, 2'b00, 0);
        add("done_vs_split",  1, 1, S2,     0, S_NONE, 1, 3'b010,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("lend_m1_s2",     1, 1, S2,     0, S_NONE, 0, 3'b000,  1, 0, 1, 1, S2,     0, 2'b00, 0);
        add("split_lend",     1, 1, S2,     1, S3,     0, 3'b010,  0, 1, 1, 1, S3,     1, 2'b01, 0);
        add("split_clr",      1, 1, S2,     1, S3,     0, 3'b000,  0, 1, 1, 1, S3,     1, 2'b01, 0);
        add("split_clr2",     1, 1, S2,     1, S3,     0, 3'b000,  0, 1, 1, 1, S3,     1, 2'b01, 0);
        add("m2_done_resume", 1, 1, S2,     1, S3,     1, 3'b000,  1, 0, 1, 1, S2,     0, 2'b00, 0);
        add("m1_done",        1, 1, S2,     0, S_NONE, 1, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("blk_m1_s2",      1, 1, S2,     0, S_NONE, 0, 3'b000,  1, 0, 1, 1, S2,     0, 2'b00, 0);
        add("park_wait",      1, 1, S2,     1, S2,     0, 3'b010,  0, 0, 1, 0, S_NONE, 0, 2'b01, 0);
        add("blocked",        1, 1, S2,     1, S2,     0, 3'b010,  0, 0, 1, 0, S_NONE, 0, 2'b01, 0);
        add("resume",         1, 1, S2,     1, S2,     0, 3'b000,  1, 0, 1, 1, S2,     0, 2'b00, 0);
        add("m1_hold",        1, 1, S2,     1, S2,     0, 3'b000,  1, 0, 1, 1, S2,     0, 2'b00, 0);
        add("m1_done2",       1, 1, S2,     1, S2,     1, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("m2_after",       1, 0, S_NONE, 1, S2,     0, 3'b000,  0, 1, 1, 1, S2,     1, 2'b00, 0);
        add("m2_done",        1, 0, S_NONE, 1, S2,     1, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("m1_s3",          1, 1, S3,     0, S_NONE, 0, 3'b000,  1, 0, 1, 1, S3,     0, 2'b00, 0);
        add("abort",          1, 0, S3,     0, S_NONE, 0, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("m1_s1",          1, 1, S1,     0, S_NONE, 0, 3'b000,  1, 0, 1, 1, S1,     0, 2'b00, 0);
        add("m1_done3",       1, 1, S1,     0, S_NONE, 1, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("m1_regrant",     1, 1, S1,     0, S_NONE, 0, 3'b000,  1, 0, 1, 1, S1,     0, 2'b00, 0);
        add("rst_mid",        0, 1, S1,     1, S3,     0, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("rst_tie",        1, 1, S1,     1, S3,     0, 3'b000,  1, 0, 1, 1, S1,     0, 2'b00, 0);
        add("tie_done",       1, 1, S1,     0, S_NONE, 1, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("w_m1_s1",        1, 1, S1,     0, S_NONE, 0, 3'b000,  1, 0, 1, 1, S1,     0, 2'b00, 0);
        add("park_s1",        1, 1, S1,     0, S_NONE, 0, 3'b001,  0, 0, 1, 0, S_NONE, 0, 2'b01, 0);
        add("borrow",         1, 1, S1,     1, S3,     0, 3'b101,  0, 1, 1, 1, S3,     1, 2'b01, 0);
        add("borrow_done",    1, 1, S1,     1, S3,     1, 3'b001,  0, 0, 1, 0, S_NONE, 0, 2'b01, 0);
        add("release_prio",   1, 1, S1,     1, S3,     0, 3'b000,  1, 0, 1, 1, S1,     0, 2'b00, 0);
        add("m1_done4",       1, 1, S1,     1, S3,     1, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("m2_go",          1, 0, S_NONE, 1, S3,     0, 3'b000,  0, 1, 1, 1, S3,     1, 2'b00, 0);
        add("m2_done2",       1, 0, S_NONE, 1, S3,     1, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);
        add("idle",           1, 0, S_NONE, 0, S_NONE, 0, 3'b000,  0, 0, 0, 0, S_NONE, 0, 2'b00, 0);

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].rst, vecs[i].m1r, vecs[i].m1id, vecs[i].m2r,
                 vecs[i].m2id, vecs[i].done, vecs[i].split, vecs[i].exp);
        end

        // Timeout: with TIMEOUT_MAX=8 the grant is visible for 8 samples, then revoked.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("tmo_hold%0d", i), 1'b1, 1'b0, S_NONE, 1'b1, S2, 1'b0, 3'b000,
                 {1'b0, 1'b1, 1'b1, 1'b1, S2, 1'b1, 2'b00, 1'b0});
        end
        step("tmo_pulse", 1'b1, 1'b0, S_NONE, 1'b1, S2, 1'b0, 3'b000,
             {1'b0, 1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 2'b00, 1'b1});
        step("tmo_after", 1'b1, 1'b0, S_NONE, 1'b0, S_NONE, 1'b0, 3'b000,
             {1'b0, 1'b0, 1'b0, 1'b0, S_NONE, 1'b0, 2'b00, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
